// File: rtl/enemy_vector_sequencer.sv
// enemy_vector_sequencer
//   Walks the vector sprite ROM of each spawned enemy (order 1 -> 2 -> 3) once
//   per frame and presents absolute DAC points over a valid/ready handshake.
//   The enemy inputs are snapshotted on frame_start and held for the frame.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   frame_start                one-cycle frame start pulse (ignored while busy)
//   spawn_enemyN, xenemyN,
//   adr_enemyN (N=1..3)        enemy active flag, x base, sprite ROM start
//   rom_addr / rom_data        sprite ROM port, data valid one cycle after addr
//   point_x/_y/_beam/_valid    point presented to the DAC driver
//   point_ready                DAC driver accepts the point
//   busy                       frame in progress
//   frame_done                 one-cycle pulse in the last cycle of a frame
//
// Build option
//   ENEMY_BLANK_MOVE_EN        emit a beam-off point at the enemy base (x, y)
//                              before the first ROM word of each sprite.
module enemy_vector_sequencer #(
    parameter int ADDRESSWIDTH = 16,
    parameter int DATAWIDTH    = 18,
    parameter int DAC_WIDTH    = 8,
    parameter int Y_ENEMY1     = 200,
    parameter int Y_ENEMY2     = 140,
    parameter int Y_ENEMY3     = 80,
    parameter int MAX_POINTS   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    spawn_enemy1,
    input  logic                    spawn_enemy2,
    input  logic                    spawn_enemy3,
    input  logic [DAC_WIDTH-1:0]    xenemy1,
    input  logic [DAC_WIDTH-1:0]    xenemy2,
    input  logic [DAC_WIDTH-1:0]    xenemy3,
    input  logic [ADDRESSWIDTH-1:0] adr_enemy1,
    input  logic [ADDRESSWIDTH-1:0] adr_enemy2,
    input  logic [ADDRESSWIDTH-1:0] adr_enemy3,
    output logic [ADDRESSWIDTH-1:0] rom_addr,
    input  logic [DATAWIDTH-1:0]    rom_data,
    output logic [DAC_WIDTH-1:0]    point_x,
    output logic [DAC_WIDTH-1:0]    point_y,
    output logic                    point_beam,
    output logic                    point_valid,
    input  logic                    point_ready,
    output logic                    busy,
    output logic                    frame_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_EMIT   = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;

    localparam int PCW = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;

    logic [2:0]                        state_q, state_d;
    logic [1:0]                        idx_q, idx_d;      // 0..2 selects enemy 1..3
    logic [ADDRESSWIDTH-1:0]           ptr_q, ptr_d;
    logic [PCW-1:0]                    pcount_q, pcount_d;
    logic [DATAWIDTH-1:0]              data_q, data_d;
    logic [2:0]                        spawn_q, spawn_d;
    logic [2:0][DAC_WIDTH-1:0]         x_q, x_d;
    logic [2:0][ADDRESSWIDTH-1:0]      adr_q, adr_d;
`ifdef ENEMY_BLANK_MOVE_EN
    logic                              blank_q, blank_d;
`endif

    logic [DAC_WIDTH-1:0] ybase;

    // Base + offset in DAC_WIDTH+1 bits, clamped to full scale on carry.
    function automatic logic [DAC_WIDTH-1:0] sat_add(input logic [DAC_WIDTH-1:0] base,
                                                     input logic [7:0]           off);
        logic [DAC_WIDTH:0] sum;
        sum = {1'b0, base} + (DAC_WIDTH+1)'(off);
        return sum[DAC_WIDTH] ? '1 : sum[DAC_WIDTH-1:0];
    endfunction

    always_comb begin
        case (idx_q)
            2'd0:    ybase = DAC_WIDTH'(Y_ENEMY1);
            2'd1:    ybase = DAC_WIDTH'(Y_ENEMY2);
            default: ybase = DAC_WIDTH'(Y_ENEMY3);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        pcount_d = pcount_q;
        data_d   = data_q;
        spawn_d  = spawn_q;
        x_d      = x_q;
        adr_d    = adr_q;
`ifdef ENEMY_BLANK_MOVE_EN
        blank_d  = blank_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    spawn_d = {spawn_enemy3, spawn_enemy2, spawn_enemy1};
                    x_d     = {xenemy3, xenemy2, xenemy1};
                    adr_d   = {adr_enemy3, adr_enemy2, adr_enemy1};
                    idx_d   = 2'd0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (spawn_q[idx_q]) begin
                    ptr_d    = adr_q[idx_q];
                    pcount_d = '0;
`ifdef ENEMY_BLANK_MOVE_EN
                    // Zero word: dx = dy = 0, beam off, not last.
                    data_d   = '0;
                    blank_d  = 1'b1;
                    state_d  = S_EMIT;
`else
                    state_d  = S_FETCH;
`endif
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                data_d  = rom_data;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (point_ready) begin
`ifdef ENEMY_BLANK_MOVE_EN
                    if (blank_q) begin
                        blank_d = 1'b0;
                        state_d = S_FETCH;
                    end else
`endif
                    if (data_q[17] || pcount_q == PCW'(MAX_POINTS - 1)) begin
                        state_d = S_NEXT;
                    end else begin
                        ptr_d    = ptr_q + 1'b1;
                        pcount_d = pcount_q + 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_NEXT: begin
                if (idx_q == 2'd2) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_SELECT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            pcount_q <= '0;
            data_q   <= '0;
            spawn_q  <= '0;
            x_q      <= '0;
            adr_q    <= '0;
`ifdef ENEMY_BLANK_MOVE_EN
            blank_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            pcount_q <= pcount_d;
            data_q   <= data_d;
            spawn_q  <= spawn_d;
            x_q      <= x_d;
            adr_q    <= adr_d;
`ifdef ENEMY_BLANK_MOVE_EN
            blank_q  <= blank_d;
`endif
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign point_valid = (state_q == S_EMIT);
    assign point_x     = point_valid ? sat_add(x_q[idx_q], data_q[15:8]) : '0;
    assign point_y     = point_valid ? sat_add(ybase, data_q[7:0]) : '0;
    assign point_beam  = point_valid & data_q[16];
    assign rom_addr    = (state_q == S_FETCH) ? ptr_q : '0;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = (state_q == S_NEXT) && (idx_q == 2'd2);

endmodule

// File: tb/tb_enemy_vector_sequencer.sv
// Directed testbench for enemy_vector_sequencer (default build, blank move off).
module tb_enemy_vector_sequencer;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        spawn_enemy1, spawn_enemy2, spawn_enemy3;
    logic [7:0]  xenemy1, xenemy2, xenemy3;
    logic [15:0] adr_enemy1, adr_enemy2, adr_enemy3;
    logic [15:0] rom_addr;
    logic [17:0] rom_data;
    logic [7:0]  point_x, point_y;
    logic        point_beam, point_valid, point_ready;
    logic        busy, frame_done;

    logic [17:0] rom [0:65535];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    enemy_vector_sequencer #(
        .ADDRESSWIDTH(16), .DATAWIDTH(18), .DAC_WIDTH(8),
        .Y_ENEMY1(200), .Y_ENEMY2(140), .Y_ENEMY3(80), .MAX_POINTS(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .spawn_enemy1(spawn_enemy1), .spawn_enemy2(spawn_enemy2), .spawn_enemy3(spawn_enemy3),
        .xenemy1(xenemy1), .xenemy2(xenemy2), .xenemy3(xenemy3),
        .adr_enemy1(adr_enemy1), .adr_enemy2(adr_enemy2), .adr_enemy3(adr_enemy3),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .point_x(point_x), .point_y(point_y), .point_beam(point_beam),
        .point_valid(point_valid), .point_ready(point_ready),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic get_point(input string tag, input int maxc,
                             output logic [16:0] pt);
        bit ok;
        ok = 1'b0;
        pt = '0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (point_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
        pt = {point_x, point_y, point_beam};
    endtask

    task automatic wait_done(input string tag, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1);
        @(negedge clk);
        check({tag, "_busy_clr"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [16:0] pt;
        int          n1, done_at, ndone;
        logic [7:0]  lastx;
        bit          got2, seen_valid;

        rst_n = 1'b0; frame_start = 1'b0; point_ready = 1'b1;
        spawn_enemy1 = 0; spawn_enemy2 = 0; spawn_enemy3 = 0;
        xenemy1 = 0; xenemy2 = 0; xenemy3 = 0;
        adr_enemy1 = 0; adr_enemy2 = 0; adr_enemy3 = 0;
        for (int a = 0; a < 65536; a++) rom[a] = '0;
        rom[16'h0100] = 18'h10503;   // beam 1, dx 5, dy 3
        rom[16'h0101] = 18'h30800;   // last, beam 1, dx 8, dy 0
        rom[16'h0200] = 18'h21464;   // last, beam 0, dx 20, dy 100
        rom[16'h0300] = 18'h20102;   // last, beam 0, dx 1, dy 2
        rom[16'h0400] = 18'h10304;   // beam 1, dx 3, dy 4
        rom[16'h0401] = 18'h20000;   // last, beam 0
        rom[16'h0500] = 18'h30000;   // last, beam 1
        for (int i = 0; i < 80; i++) rom[16'h1000 + i] = 18'h10000 | 18'(i << 8);

        // Reset state
        #1;
        check("rst_valid", point_valid, 0);
        check("rst_ctrl", {busy, frame_done, point_beam}, 0);
        check("rst_xy", {point_x, point_y}, 0);
        check("rst_addr", rom_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Enemy1 only, two points, ready high
        spawn_enemy1 = 1; xenemy1 = 8'd10; adr_enemy1 = 16'h0100;
        start_frame();
        check("t2_busy", busy, 1);
        get_point("t2_p1_seen", 20, pt);
        check("t2_p1", pt, {8'd15, 8'd203, 1'b1});
        @(negedge clk);
        check("t2_one_cycle_xfer", point_valid, 0);
        get_point("t2_p2_seen", 20, pt);
        check("t2_p2", pt, {8'd18, 8'd200, 1'b1});
        wait_done("t2_done", 20);

        // Saturation on enemy1, then enemy3 (y base 80)
        xenemy1 = 8'd250; adr_enemy1 = 16'h0200;
        spawn_enemy3 = 1; xenemy3 = 8'd7; adr_enemy3 = 16'h0300;
        start_frame();
        get_point("t3_sat_seen", 20, pt);
        check("t3_sat", pt, {8'd255, 8'd255, 1'b0});
        get_point("t3_e3_seen", 20, pt);
        check("t3_e3", pt, {8'd8, 8'd82, 1'b0});
        wait_done("t3_done", 20);

        // Backpressure on enemy2
        spawn_enemy1 = 0; spawn_enemy3 = 0;
        spawn_enemy2 = 1; xenemy2 = 8'd100; adr_enemy2 = 16'h0400;
        point_ready = 1'b0;
        start_frame();
        get_point("t4_p1_seen", 20, pt);
        check("t4_p1", pt, {8'd103, 8'd144, 1'b1});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_hold", {point_valid, point_x, point_y, point_beam},
                  {1'b1, 8'd103, 8'd144, 1'b1});
        end
        point_ready = 1'b1;
        @(negedge clk);
        check("t4_xfer_on_ready", point_valid, 0);
        check("t4_next_addr", rom_addr, 32'h0401);
        get_point("t4_p2_seen", 20, pt);
        check("t4_p2", pt, {8'd100, 8'd140, 1'b0});
        wait_done("t4_done", 20);

        // Runaway guard: enemy1 sprite without last bit, then enemy2
        spawn_enemy1 = 1; xenemy1 = 8'd0; adr_enemy1 = 16'h1000;
        xenemy2 = 8'd50; adr_enemy2 = 16'h0500;
        start_frame();
        n1 = 0; lastx = '0; got2 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            get_point("t5_pt_seen", 20, pt);
            if (pt[8:1] == 8'd200) begin
                n1++;
                lastx = pt[16:9];
            end else begin
                got2 = 1'b1;
                break;
            end
        end
        check("t5_count", n1, 64);
        check("t5_lastx", lastx, 63);
        check("t5_e2_seen", got2, 1);
        check("t5_e2", pt, {8'd50, 8'd140, 1'b1});
        wait_done("t5_done", 20);

        // No enemies: frame_done six cycles after frame_start
        spawn_enemy1 = 0; spawn_enemy2 = 0; spawn_enemy3 = 0;
        frame_start = 1'b1;
        done_at = 0; seen_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) frame_start = 1'b0;
            if (frame_done && done_at == 0) done_at = k;
            if (point_valid) seen_valid = 1'b1;
        end
        check("t6_done_at", done_at, 6);
        check("t6_no_valid", seen_valid, 0);

        // Second frame_start mid-frame with enemy2 active is ignored
        frame_start = 1'b1;
        done_at = 0; ndone = 0; seen_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (frame_done) begin
                ndone++;
                if (done_at == 0) done_at = k;
            end
            if (point_valid) seen_valid = 1'b1;
            if (k == 1) frame_start = 1'b0;
            if (k == 3) begin
                spawn_enemy2 = 1'b1;
                frame_start  = 1'b1;
            end
            if (k == 4) frame_start = 1'b0;
        end
        check("t6b_done_at", done_at, 6);
        check("t6b_ndone", ndone, 1);
        check("t6b_no_valid", seen_valid, 0);
        check("t6b_idle", busy, 0);

        // Reset while a point is presented
        spawn_enemy2 = 0;
        spawn_enemy1 = 1; xenemy1 = 8'd10; adr_enemy1 = 16'h0100;
        point_ready = 1'b0;
        start_frame();
        get_point("t7_seen", 20, pt);
        check("t7_p1", pt, {8'd15, 8'd203, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_valid", point_valid, 0);
        check("t7_async_ctrl", {busy, frame_done, point_beam}, 0);
        check("t7_async_xy", {point_x, point_y}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t7_stay_idle", {busy, point_valid, frame_done}, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
